// File: rtl/spi_master_frame.sv
// Full-duplex SPI master: sends one CS_N frame of frame_len DATA_W-bit words, MSB first,
// with runtime CPOL/CPHA and SCK divider; every captured MISO word is returned on rx_data.
//   state     | meaning
//   S_IDLE    | CS_N high, waiting for start
//   S_SETUP   | CS_N low, setup delay before the first word
//   S_LOAD    | tx_ready high, waiting for a TX word (frame stretches on underrun)
//   S_SHIFT   | 2*DATA_W SCK half-periods, then word end
//   S_GAP     | idle SCK between words
//   S_HOLD    | CS_N low after the last SCK edge
//   S_RECOVER | CS_N high minimum idle, busy still set
module spi_master_frame #(
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 8,
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 16,
  parameter int CS_HOLD  = 16,
  parameter int CS_IDLE  = 32,
  parameter int WORD_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              CS_N,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);

  // Setup count absorbs the LOAD handshake and one div=1 half-period, hold absorbs the
  // word-end cycle, so CS_N-to-edge and edge-to-CS_N land on exactly CS_SETUP / CS_HOLD.
  localparam int SETUP_N = (CS_SETUP > 3) ? CS_SETUP - 3 : 0;
  localparam int HOLD_N  = (CS_HOLD > 2) ? CS_HOLD - 2 : 0;
  localparam int IDLE_N  = (CS_IDLE > 1) ? CS_IDLE - 1 : 0;
  localparam int GAP_N   = (WORD_GAP > 1) ? WORD_GAP - 1 : 0;
  localparam int DIV_MAX = (1 << DIV_W) - 1;
  localparam int T_M1    = (SETUP_N > HOLD_N) ? SETUP_N : HOLD_N;
  localparam int T_M2    = (IDLE_N > GAP_N) ? IDLE_N : GAP_N;
  localparam int T_M3    = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int T_MAX   = (T_M3 > DIV_MAX) ? T_M3 : DIV_MAX;
  localparam int TMR_W   = $clog2(T_MAX + 1);
  localparam int HC_W    = $clog2(2 * DATA_W + 1);

  localparam logic [TMR_W-1:0] SETUP_T = TMR_W'(SETUP_N);
  localparam logic [TMR_W-1:0] HOLD_T  = TMR_W'(HOLD_N);
  localparam logic [TMR_W-1:0] IDLE_T  = TMR_W'(IDLE_N);
  localparam logic [TMR_W-1:0] GAP_T   = TMR_W'(GAP_N);
  localparam logic [HC_W-1:0]  HC_LAST = HC_W'(2 * DATA_W - 1);
  localparam logic [HC_W-1:0]  HC_END  = HC_W'(2 * DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_GAP, S_HOLD, S_RECOVER
  } state_t;

  state_t             state;
  logic               cpol_q, cpha_q;
  logic [DIV_W-1:0]   div_m1;
  logic [LEN_W-1:0]   words_left;
  logic [TMR_W-1:0]   tmr;
  logic [HC_W-1:0]    hcnt;
  logic [DATA_W-1:0]  tx_sh, rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_m1     <= '0;
      words_left <= '0;
      tmr        <= '0;
      hcnt       <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      tx_ready   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      CS_N       <= 1'b1;
      SCK        <= 1'b0;
      MOSI       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && frame_len != '0) begin
            cpol_q     <= cpol;
            cpha_q     <= cpha;
            div_m1     <= (clk_div == '0) ? '0 : clk_div - 1'b1;
            words_left <= frame_len;
            busy       <= 1'b1;
            CS_N       <= 1'b0;
            SCK        <= cpol;
            tmr        <= SETUP_T;
            state      <= S_SETUP;
          end
        end
        S_SETUP, S_GAP: begin
          if (tmr == '0) begin
            tx_ready <= 1'b1;
            state    <= S_LOAD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_LOAD: begin
          if (tx_valid) begin
            tx_ready <= 1'b0;
            if (!cpha_q) begin
              MOSI  <= tx_data[DATA_W-1];
              tx_sh <= {tx_data[DATA_W-2:0], 1'b0};
            end else begin
              tx_sh <= tx_data;
            end
            hcnt  <= '0;
            tmr   <= TMR_W'(div_m1);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (hcnt == HC_END) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            if (words_left == LEN_W'(1)) begin
              tmr   <= HOLD_T;
              state <= S_HOLD;
            end else begin
              words_left <= words_left - 1'b1;
              if (WORD_GAP == 0) begin
                tx_ready <= 1'b1;
                state    <= S_LOAD;
              end else begin
                tmr   <= GAP_T;
                state <= S_GAP;
              end
            end
          end else if (tmr == '0) begin
            SCK  <= ~SCK;
            hcnt <= hcnt + 1'b1;
            tmr  <= TMR_W'(div_m1);
            // even hcnt = leading edge; sample on the edge matching cpha, shift on the other
            if (hcnt[0] == cpha_q) begin
              rx_sh <= {rx_sh[DATA_W-2:0], MISO};
            end else if (hcnt != HC_LAST) begin
              MOSI  <= tx_sh[DATA_W-1];
              tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_HOLD: begin
          if (tmr == '0) begin
            CS_N  <= 1'b1;
            done  <= 1'b1;
            tmr   <= IDLE_T;
            state <= S_RECOVER;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_RECOVER: begin
          if (tmr == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_frame.sv
// Bench for spi_master_frame: behavioural SPI slave plus word-level scoreboard of MOSI/MISO
// traffic, CS_N timing and handshake behaviour across modes, dividers and frame lengths.
module tb_spi_master_frame;
  localparam int DW       = 8;
  localparam int CS_SETUP = 16;
  localparam int CS_HOLD  = 16;
  localparam int CS_IDLE  = 32;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0]    clk_div = 8'd1, frame_len = 8'd0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, rx_valid, busy, done, CS_N, SCK, MOSI;
  logic [DW-1:0] rx_data;
  logic          MISO = 1'b0;

  spi_master_frame #(.DATA_W(DW), .DIV_W(8), .LEN_W(8), .CS_SETUP(CS_SETUP),
                     .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .WORD_GAP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .frame_len(frame_len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .CS_N(CS_N),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO));

  always #20 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave/source configuration, written by the stimulus process
  logic          m_cpol = 0, m_cpha = 0, loopback = 0, stall_en = 0;
  logic [DW-1:0] src_w [0:255];
  logic [DW-1:0] sl_w  [0:255];
  int            src_len = 0;

  // observations, written by the monitor
  int  src_idx = 0, stall_cnt = 0, stall_bad = 0, edge_cnt = 0, shift_cnt = 0, nbits = 0;
  int  n_fall = 0, n_done = 0, fall_cyc = 0, rise_cyc = 0, first_cyc = 0, last_cyc = 0;
  int  rx_cyc = 0, high_len = -1;
  bit  rise_seen = 0, hs_pending = 0, lead = 0;
  logic prev_csn = 1'b1, prev_sck = 1'b0;
  logic [DW-1:0] cur = '0;
  logic [DW-1:0] mosi_w[$];
  logic [DW-1:0] rx_w[$];

  function automatic logic sl_bit(input int n);
    int w;
    w = n / DW;
    if (w > 255) return 1'b0;
    return sl_w[w][DW-1-(n%DW)];
  endfunction

  always @(negedge clk) begin
    if (prev_csn && !CS_N) begin
      n_fall++;
      fall_cyc = cyc;
      if (rise_seen) high_len = cyc - rise_cyc;
      edge_cnt = 0; shift_cnt = 0; nbits = 0; src_idx = 0;
      stall_cnt = 0; stall_bad = 0; hs_pending = 0;
      mosi_w.delete(); rx_w.delete();
    end
    if (!prev_csn && CS_N) begin
      rise_cyc = cyc;
      rise_seen = 1;
    end
    if (!prev_csn && !CS_N && SCK !== prev_sck) begin
      edge_cnt++;
      if (edge_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
      lead = (SCK != m_cpol);
      if (lead == !m_cpha) begin
        cur = {cur[DW-2:0], MOSI};
        nbits++;
        if (nbits % DW == 0) mosi_w.push_back(cur);
      end
      if (lead == m_cpha) shift_cnt++;
    end
    if (rx_valid) begin
      rx_w.push_back(rx_data);
      rx_cyc = cyc;
    end
    if (done) n_done++;
    if (loopback) MISO = MOSI;
    else if (!m_cpha) MISO = sl_bit(shift_cnt);
    else MISO = (shift_cnt == 0) ? 1'b0 : sl_bit(shift_cnt - 1);
    if (hs_pending) src_idx++;
    hs_pending = 0;
    if (src_idx < src_len && !(stall_en && src_idx == 1 && stall_cnt < 50)) begin
      tx_valid = 1'b1;
      tx_data  = src_w[src_idx];
    end else begin
      tx_valid = 1'b0;
      if (stall_en && src_idx == 1 && stall_cnt < 50 && tx_ready) begin
        stall_cnt++;
        if (SCK !== m_cpol || CS_N !== 1'b0) stall_bad++;
      end
    end
    hs_pending = tx_valid && tx_ready;
    prev_csn = CS_N;
    prev_sck = SCK;
  end

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      src_w[i] = DW'($urandom);
      sl_w[i]  = DW'($urandom);
    end
  endtask

  task automatic run_frame(input string nm, input bit pol, input bit pha, input int div,
                           input int len, input bit lb, input bit stall, input bit exact,
                           input bit poke);
    int d0, f0, lim;
    logic [DW-1:0] exp_rx;
    m_cpol = pol; m_cpha = pha; loopback = lb; stall_en = stall; src_len = len;
    d0 = n_done; f0 = n_fall;
    @(negedge clk);
    start = 1'b1; cpol = pol; cpha = pha; clk_div = 8'(div); frame_len = 8'(len);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (100) @(negedge clk);
      start = 1'b1; cpol = ~pol; cpha = ~pha; clk_div = 8'd9; frame_len = 8'd5;
      @(negedge clk);
      start = 1'b0;
      check({nm, " busy after ignored start"}, 32'(busy), 32'd1);
    end
    lim = 400 + len * (40 * (div + 1) + 80);
    for (int i = 0; i < lim && n_done == d0; i++) @(negedge clk);
    check({nm, " done count"}, 32'(n_done - d0), 32'd1);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check({nm, " busy low"}, 32'(busy), 32'd0);
    check({nm, " CS_N falls"}, 32'(n_fall - f0), 32'd1);
    check({nm, " SCK edges"}, 32'(edge_cnt), 32'(16 * len));
    check({nm, " mosi words"}, 32'(mosi_w.size()), 32'(len));
    check({nm, " rx words"}, 32'(rx_w.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      exp_rx = lb ? src_w[i] : sl_w[i];
      if (i < mosi_w.size()) check($sformatf("%s mosi[%0d]", nm, i), 32'(mosi_w[i]), 32'(src_w[i]));
      if (i < rx_w.size()) check($sformatf("%s rx[%0d]", nm, i), 32'(rx_w[i]), 32'(exp_rx));
    end
    check({nm, " hold cycles"}, 32'(rise_cyc - last_cyc), 32'(CS_HOLD));
    check({nm, " rx_valid lag"}, 32'(rx_cyc - last_cyc), 32'd1);
    if (exact) check({nm, " setup cycles"}, 32'(first_cyc - fall_cyc), 32'(CS_SETUP));
    else check($sformatf("%s setup>=%0d (%0d)", nm, CS_SETUP, first_cyc - fall_cyc),
               32'(first_cyc - fall_cyc >= CS_SETUP), 32'd1);
    check({nm, " idle SCK"}, 32'(SCK), 32'(pol));
    check({nm, " idle CS_N"}, 32'(CS_N), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, f0;
    bit p, h;
    @(negedge clk);
    check("reset CS_N", 32'(CS_N), 32'd1);
    check("reset SCK", 32'(SCK), 32'd0);
    check("reset MOSI", 32'(MOSI), 32'd0);
    check("reset tx_ready", 32'(tx_ready), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    src_w[0] = 8'hAA; src_w[1] = 8'h55; src_w[2] = 8'hA4;
    run_frame("mode3 loopback", 1, 1, 4, 3, 1, 0, 0, 0);

    for (int m = 0; m < 3; m++) begin
      src_w[0] = 8'hA5; sl_w[0] = 8'h3C;
      run_frame($sformatf("mode%0d", m), m[1], m[0], $urandom_range(1, 3), 1, 0, 0, 0, 0);
    end

    fill_random(1);
    p = 1'($urandom); h = 1'($urandom);
    run_frame("timing a", p, h, 1, 1, 0, 0, 1, 0);
    fill_random(1);
    run_frame("timing b", p, h, 1, 1, 0, 0, 1, 0);
    check($sformatf("CS_N high %0d >= %0d", high_len, CS_IDLE), 32'(high_len >= CS_IDLE), 32'd1);

    fill_random(3);
    run_frame("underrun", 1'($urandom), 1'($urandom), 2, 3, 0, 1, 0, 0);
    check("underrun stall cycles", 32'(stall_cnt), 32'd50);
    check("underrun idle bus", 32'(stall_bad), 32'd0);

    fill_random(2);
    run_frame("start while busy", 0, 1, 3, 2, 0, 0, 0, 1);
    f0 = n_fall;
    @(negedge clk);
    frame_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0 busy", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check("len0 no CS_N fall", 32'(n_fall - f0), 32'd0);
    check("len0 CS_N", 32'(CS_N), 32'd1);

    fill_random(3);
    sl_w[0] = 8'h81;
    src_len = 3; m_cpol = 1; m_cpha = 0; loopback = 0; stall_en = 0;
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; cpol = 1'b1; cpha = 1'b0; clk_div = 8'd4; frame_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && edge_cnt < 20; i++) @(negedge clk);
    check("rst reached word 2", 32'(edge_cnt >= 20), 32'd1);
    #5 rst = 1'b1;
    #1;
    check("rst CS_N", 32'(CS_N), 32'd1);
    check("rst SCK", 32'(SCK), 32'd0);
    check("rst MOSI", 32'(MOSI), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tx_ready", 32'(tx_ready), 32'd0);
    check("rst rx_data", 32'(rx_data), 32'd0);
    check("rst done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst no done pulse", 32'(n_done - d0), 32'd0);
    fill_random(2);
    run_frame("after rst", 0, 0, 2, 2, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 4);
      fill_random(len);
      run_frame($sformatf("rand%0d", r), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                len, 1'($urandom), 1'($urandom), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
